// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the parametrised FIFO: pointer width and parameter legality checks.
package sync_fifo_pkg;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Legal combination: DEPTH a power of two >= 4, DATA_W >= 1,
    // 0 <= AE_LEVEL < AF_LEVEL <= DEPTH.
    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af_level, input int ae_level);
        return (data_w >= 1) && (depth >= 4) && is_pow2(depth) &&
               (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-facing bundle of the FIFO. The FIFO takes the slave side;
// whatever drives requests takes the master side.
//
// Handshake: a write is accepted on a rising edge where wr=1 and full=0; a read
// is accepted on a rising edge where rd=1 and empty=0, with data_out/rd_valid
// presenting the word after that edge. Requests against full/empty are dropped
// and flagged by a one-cycle overflow/underflow pulse. clear flushes and
// overrides any request in the same cycle.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) ();
    import sync_fifo_pkg::*;

    localparam int CW = ptr_w(DEPTH);

    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic              clear;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, data_in, rd, clear,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr, data_in, rd, clear,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// Kept separate so a vendor memory macro can be dropped in.
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              re_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; holds its value when no read is enabled.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointer/flag control around a swappable RAM.
// All DEPTH entries are usable thanks to an extra wrap bit on each pointer.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic clock,
    input  logic rst,
    sync_fifo_param_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    // Reject illegal parameter combinations at elaboration.
    if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
        $fatal(1, "sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    // Set by the first accepted read after reset; masks the unreset RAM
    // read register so data_out reads as zero until a real word arrives.
    logic              dout_seen_q, dout_seen_d;

    logic              full;
    logic              empty;
    logic [PW-1:0]     count;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] mem_rd_data;

    // Status flags from registered pointers.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Accept decisions use start-of-cycle flags; reset and clear suppress both.
    assign wr_acc = rst && !bus.clear && bus.wr && !full;
    assign rd_acc = rst && !bus.clear && bus.rd && !empty;

    // Next-state for pointers, strobes and error pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_valid_d  = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        dout_seen_d = dout_seen_q;
        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                rd_valid_d  = 1'b1;
                dout_seen_d = 1'b1;
            end
            overflow_d  = bus.wr && full;
            underflow_d = bus.rd && empty;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_seen_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_seen_q <= dout_seen_d;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i     (clock),
        .we_i      (wr_acc),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (bus.data_in),
        .re_i      (rd_acc),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (mem_rd_data)
    );

    assign bus.data_out     = dout_seen_q ? mem_rd_data : '0;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count;
    assign bus.almost_full  = (count >= AF_L);
    assign bus.almost_empty = (count <= AE_L);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, successor to the fixed 8-bit × 32 FIFO. Generalises data width and depth, makes all DEPTH entries usable, and adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, read-valid strobe and overflow/underflow error pulses. Sits between a producer and a consumer in the same clock domain as the buffering stage of the datapath.

## Interface
- DATA_W, 8: data word width in bits, ≥1.
- DEPTH, 32: number of entries; power of two, ≥4.
- AF_LEVEL, DEPTH-4: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL.
- clock  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the clock edge.
- wr  in  1  write request.
- data_in  in  DATA_W  write data, sampled when a write is accepted.
- rd  in  1  read request.
- clear  in  1  synchronous flush; empties the FIFO without reset.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  data_out updated this cycle (1-cycle pulse).
- full / empty  out  1  status flags, combinational from pointers.
- almost_full / almost_empty  out  1  threshold flags.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow / underflow  out  1  1-cycle error pulses.

## Operation
- Pointers are $clog2(DEPTH)+1 bits wide (extra wrap bit). empty = (wr_ptr == rd_ptr); full = address bits equal, wrap bits differ. All DEPTH entries usable.
- count = wr_ptr − rd_ptr, modulo 2^(AW+1); never exceeds DEPTH.
- Write accepted iff wr=1 and full=0 at the clock edge: mem[wr_ptr addr] ← data_in, wr_ptr += 1.
- Read accepted iff rd=1 and empty=0: data_out ← mem[rd_ptr addr], rd_ptr += 1, rd_valid = 1 next cycle. Otherwise data_out holds its value and rd_valid = 0.
- Flags use start-of-cycle state. On full: simultaneous rd+wr → read accepted, write rejected. On empty: simultaneous rd+wr → write accepted, read rejected. Otherwise both accepted together; count unchanged.
- overflow = 1 for one cycle after wr=1 while full; underflow = 1 for one cycle after rd=1 while empty. Rejected requests change no state.
- Pointer wrap is natural binary roll-over; no special case.
- clear=1: both pointers → 0, rd_valid → 0, overflow/underflow → 0; data_out holds; memory contents untouched; concurrent wr/rd ignored.
- Reset (rst=0): pointers, count, data_out, rd_valid, overflow, underflow → 0. Memory is not cleared. Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=0, count=0. Reset takes priority over clear and mid-operation traffic; all queued data is discarded.

## Timing
- Write-to-flag latency: 1 cycle; empty deasserts the cycle after the first accepted write.
- Read latency: data_out/rd_valid valid 1 cycle after the accepted rd edge.
- Minimum write-to-read: a word written at edge N can be read at edge N+1 and appears on data_out after edge N+1.
- Sustained throughput: one write and one read per cycle.
- full/empty/almost_*/count are combinational from registered pointers: no glitch-free guarantee within a cycle, stable at the edge.

## Structure
- Package sync_fifo_pkg: function for pointer width (clog2(DEPTH)+1) and parameter-check helpers (DEPTH power of two, AE_LEVEL < AF_LEVEL ≤ DEPTH).
- Sub-module sync_fifo_mem: simple dual-port RAM (DATA_W × DEPTH, one write port, registered read port, no reset) so it can be swapped for a vendor macro. Control, pointers and flags stay in sync_fifo_param.
- Elaboration-time assertion fails on an illegal parameter combination.

## Test plan
- Reset: hold rst=0 for 2 cycles with wr=1 -> count=0, empty=1, data_out=0, no write recorded.
- Fill/drain, DATA_W=8, DEPTH=32: write 0x00..0x1F -> full=1 after the 32nd write, count=32. Read 32 -> data_out 0x00..0x1F in order with rd_valid, then empty=1.
- Boundaries: wr while full -> overflow pulse, contents unchanged. rd while empty -> underflow pulse, data_out held. rd+wr on full -> count 32→31. rd+wr on empty -> count 0→1.
- Wrap: 100 cycles of interleaved rd+wr at count=5 -> FIFO order preserved across pointer roll-over, count stays 5.
- Thresholds: fill to 28 -> almost_full=1 (AF_LEVEL=28). Drain to 4 -> almost_empty=1, and 0 at count=5.
- Flush/reset mid-operation: at count=10 assert clear -> count=0, empty=1 next cycle. Refill 3 and assert rst=0 -> all outputs at reset values.
